// File: rtl/timer_service_master.sv
// timer_service_master: Avalon-MM initiator that programs an interval-timer
// slave, services its timeout interrupts, counts ticks and reads counter
// snapshots on request.
module timer_service_master #(
  parameter int unsigned TICK_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [31:0]       period,
  input  logic              continuous,
  input  logic              stop,
  input  logic              snap_req,
  input  logic              irq,
  output logic [2:0]        m_address,
  output logic              m_chipselect,
  output logic              m_write_n,
  output logic [15:0]       m_writedata,
  input  logic [15:0]       m_readdata,
  output logic              busy,
  output logic [TICK_W-1:0] tick_count,
  output logic              tick,
  output logic [31:0]       snapshot,
  output logic              snap_valid,
  output logic              done
);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_PL, S_WR_PH, S_WR_CTRL, S_RUN, S_CLR_STAT, S_CLR_WAIT,
    S_SNAP_CAP, S_SNAP_RDL, S_SNAP_RDH, S_SNAP_FIN, S_WR_STOP
  } state_t;

  localparam logic [2:0] A_STATUS = 3'd0;
  localparam logic [2:0] A_CTRL   = 3'd1;
  localparam logic [2:0] A_PER_L  = 3'd2;
  localparam logic [2:0] A_PER_H  = 3'd3;
  localparam logic [2:0] A_SNAP_L = 3'd4;
  localparam logic [2:0] A_SNAP_H = 3'd5;

  state_t      state, state_nx;
  logic [31:0] period_q;
  logic        cont_q;

  logic        cs_nx;
  logic        wr_n_nx;
  logic [2:0]  addr_nx;
  logic [15:0] wdata_nx;

  // Next-state selection, then bus values for the state being entered so the
  // bus registers line up with the state register.
  always_comb begin
    state_nx = state;
    cs_nx    = 1'b0;
    wr_n_nx  = 1'b1;
    addr_nx  = '0;
    wdata_nx = '0;

    case (state)
      S_IDLE:     if (start) state_nx = S_WR_PL;
      S_WR_PL:    state_nx = S_WR_PH;
      S_WR_PH:    state_nx = S_WR_CTRL;
      S_WR_CTRL:  state_nx = S_RUN;
      S_RUN: begin
        if (stop)          state_nx = S_WR_STOP;
        else if (irq)      state_nx = S_CLR_STAT;
        else if (snap_req) state_nx = S_SNAP_CAP;
      end
      S_CLR_STAT: state_nx = S_CLR_WAIT;
      S_CLR_WAIT: state_nx = cont_q ? S_RUN : S_IDLE;
      S_SNAP_CAP: state_nx = S_SNAP_RDL;
      S_SNAP_RDL: state_nx = S_SNAP_RDH;
      S_SNAP_RDH: state_nx = S_SNAP_FIN;
      S_SNAP_FIN: state_nx = S_RUN;
      S_WR_STOP:  state_nx = S_IDLE;
      default:    state_nx = S_IDLE;
    endcase

    // WR_PL is only entered from IDLE on the same edge that latches period_q,
    // so its data comes straight from the period input.
    case (state_nx)
      S_WR_PL:    begin cs_nx = 1'b1; wr_n_nx = 1'b0; addr_nx = A_PER_L; wdata_nx = period[15:0]; end
      S_WR_PH:    begin cs_nx = 1'b1; wr_n_nx = 1'b0; addr_nx = A_PER_H; wdata_nx = period_q[31:16]; end
      S_WR_CTRL:  begin cs_nx = 1'b1; wr_n_nx = 1'b0; addr_nx = A_CTRL;
                        wdata_nx = cont_q ? 16'h0007 : 16'h0005; end
      S_CLR_STAT: begin cs_nx = 1'b1; wr_n_nx = 1'b0; addr_nx = A_STATUS; end
      S_SNAP_CAP: begin cs_nx = 1'b1; wr_n_nx = 1'b0; addr_nx = A_SNAP_L; end
      S_SNAP_RDL: begin cs_nx = 1'b1; addr_nx = A_SNAP_L; end
      S_SNAP_RDH: begin cs_nx = 1'b1; addr_nx = A_SNAP_H; end
      S_WR_STOP:  begin cs_nx = 1'b1; wr_n_nx = 1'b0; addr_nx = A_CTRL; wdata_nx = 16'h0008; end
      default:    ;
    endcase
  end

  // State, registered bus, configuration latch, tick counter and snapshot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      period_q     <= '0;
      cont_q       <= 1'b0;
      m_chipselect <= 1'b0;
      m_write_n    <= 1'b1;
      m_address    <= '0;
      m_writedata  <= '0;
      busy         <= 1'b0;
      tick_count   <= '0;
      tick         <= 1'b0;
      snapshot     <= '0;
      snap_valid   <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_nx;
      m_chipselect <= cs_nx;
      m_write_n    <= wr_n_nx;
      m_address    <= addr_nx;
      m_writedata  <= wdata_nx;
      busy         <= (state_nx != S_IDLE);
      tick         <= (state_nx == S_CLR_STAT);
      done         <= (state_nx == S_IDLE) && (state != S_IDLE);
      snap_valid   <= (state == S_SNAP_FIN);

      if (state == S_IDLE && start) begin
        period_q <= period;
        cont_q   <= continuous;
      end
      if (state_nx == S_CLR_STAT)
        tick_count <= tick_count + TICK_W'(1);
      if (state == S_SNAP_RDH)
        snapshot[15:0] <= m_readdata;
      if (state == S_SNAP_FIN)
        snapshot[31:16] <= m_readdata;
    end
  end

endmodule

// File: tb/tb_timer_service_master.sv
// Bench for timer_service_master: directed steps, bus transactions checked
// against an expected-access queue, plus a 4-bit tick-counter twin.
module tb_timer_service_master;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, continuous, stop, snap_req, irq;
  logic [31:0] period;
  logic [15:0] m_readdata;

  logic [2:0]  m_address;
  logic        m_chipselect, m_write_n;
  logic [15:0] m_writedata;
  logic        busy, tick, snap_valid, done;
  logic [15:0] tick_count;
  logic [31:0] snapshot;

  logic [2:0]  b_address;
  logic        b_chipselect, b_write_n;
  logic [15:0] b_writedata;
  logic        b_busy, b_tick, b_snap_valid, b_done;
  logic [3:0]  b_tick_count;
  logic [31:0] b_snapshot;

  int total = 0;
  int bad   = 0;
  int tick_seen = 0, done_seen = 0, snapv_seen = 0;

  typedef struct {
    logic [2:0]  a;
    logic        wn;
    logic [15:0] d;
  } acc_t;
  acc_t exp_q[$];

  timer_service_master #(.TICK_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .period(period),
    .continuous(continuous), .stop(stop), .snap_req(snap_req), .irq(irq),
    .m_address(m_address), .m_chipselect(m_chipselect), .m_write_n(m_write_n),
    .m_writedata(m_writedata), .m_readdata(m_readdata), .busy(busy),
    .tick_count(tick_count), .tick(tick), .snapshot(snapshot),
    .snap_valid(snap_valid), .done(done)
  );

  timer_service_master #(.TICK_W(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .start(start), .period(period),
    .continuous(continuous), .stop(stop), .snap_req(snap_req), .irq(irq),
    .m_address(b_address), .m_chipselect(b_chipselect), .m_write_n(b_write_n),
    .m_writedata(b_writedata), .m_readdata(m_readdata), .busy(b_busy),
    .tick_count(b_tick_count), .tick(b_tick), .snapshot(b_snapshot),
    .snap_valid(b_snap_valid), .done(b_done)
  );

  always #5 clk = ~clk;

  // Registered-readdata slave model for the snapshot registers
  always @(posedge clk) begin
    if (m_chipselect && m_write_n)
      m_readdata <= (m_address == 3'd4) ? 16'h1234 :
                    (m_address == 3'd5) ? 16'h0001 : 16'h0000;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic exp_bus(input logic [2:0] a, input logic wn, input logic [15:0] d);
    acc_t e;
    e.a = a; e.wn = wn; e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // Bus monitor: every access pops an expected entry; idle cycles must be idle
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (m_chipselect) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $error("FAIL bus_unexpected observed=addr %0d wn %0b data %h expected=no access",
                 m_address, m_write_n, m_writedata);
        end else begin
          acc_t e;
          e = exp_q.pop_front();
          check("bus_addr", 32'(m_address), 32'(e.a));
          check("bus_write_n", 32'(m_write_n), 32'(e.wn));
          check("bus_wdata", 32'(m_writedata), 32'(e.d));
        end
      end else begin
        check("idle_addr", 32'(m_address), 32'd0);
        check("idle_write_n", 32'(m_write_n), 32'd1);
        check("idle_wdata", 32'(m_writedata), 32'd0);
      end
      if (tick)       tick_seen++;
      if (done)       done_seen++;
      if (snap_valid) snapv_seen++;
    end
  end

  initial begin
    reset_n = 1'b0; start = 1'b0; continuous = 1'b0; stop = 1'b0;
    snap_req = 1'b0; irq = 1'b0; period = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cs", 32'(m_chipselect), 32'd0);
    check("rst_write_n", 32'(m_write_n), 32'd1);
    check("rst_tick_count", 32'(tick_count), 32'd0);
    check("rst_snapshot", snapshot, 32'd0);
    check("rst_pulses", {29'd0, tick, snap_valid, done}, 32'd0);
    cyc();
    reset_n = 1'b1;

    // Continuous start: period low, period high, control with CONT
    exp_bus(3'd2, 1'b0, 16'h0003); exp_bus(3'd3, 1'b0, 16'h0001); exp_bus(3'd1, 1'b0, 16'h0007);
    period = 32'h0001_0003; continuous = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0; period = '0; continuous = 1'b0;
    @(negedge clk);
    check("prog_busy", 32'(busy), 32'd1);
    repeat (4) cyc();
    check("run_busy", 32'(busy), 32'd1);
    check("run_tick_count", 32'(tick_count), 32'd0);

    // irq held two cycles: exactly one status clear
    exp_bus(3'd0, 1'b0, 16'h0000);
    irq = 1'b1; cyc(); cyc(); irq = 1'b0;
    repeat (4) cyc();
    check("irq_tick_count", 32'(tick_count), 32'd1);
    check("irq_tick_pulses", 32'(tick_seen), 32'd1);
    check("irq_still_run", 32'(busy), 32'd1);

    // Snapshot: capture write, read low, read high
    exp_bus(3'd4, 1'b0, 16'h0000); exp_bus(3'd4, 1'b1, 16'h0000); exp_bus(3'd5, 1'b1, 16'h0000);
    snap_req = 1'b1; cyc(); snap_req = 1'b0;
    repeat (6) cyc();
    check("snap_value", snapshot, 32'h0001_1234);
    check("snap_valid_pulses", 32'(snapv_seen), 32'd1);

    // stop wins over irq in the same cycle
    exp_bus(3'd1, 1'b0, 16'h0008);
    stop = 1'b1; irq = 1'b1; cyc(); stop = 1'b0; irq = 1'b0;
    repeat (3) cyc();
    check("stop_done", 32'(done_seen), 32'd1);
    check("stop_busy", 32'(busy), 32'd0);
    check("stop_tick_count", 32'(tick_count), 32'd1);

    // One-shot: control 0x0005, one service, back to IDLE
    exp_bus(3'd2, 1'b0, 16'h0010); exp_bus(3'd3, 1'b0, 16'h0000); exp_bus(3'd1, 1'b0, 16'h0005);
    period = 32'h0000_0010; continuous = 1'b0; start = 1'b1;
    cyc(); start = 1'b0;
    repeat (4) cyc();
    exp_bus(3'd0, 1'b0, 16'h0000);
    irq = 1'b1; cyc(); cyc(); irq = 1'b0;
    repeat (4) cyc();
    check("oneshot_done", 32'(done_seen), 32'd2);
    check("oneshot_busy", 32'(busy), 32'd0);
    check("oneshot_tick_count", 32'(tick_count), 32'd2);

    // Counter wrap on the 4-bit twin: 16 services total
    exp_bus(3'd2, 1'b0, 16'h0005); exp_bus(3'd3, 1'b0, 16'h0000); exp_bus(3'd1, 1'b0, 16'h0007);
    period = 32'h0000_0005; continuous = 1'b1; start = 1'b1;
    cyc(); start = 1'b0;
    repeat (4) cyc();
    for (int i = 0; i < 14; i++) begin
      exp_bus(3'd0, 1'b0, 16'h0000);
      irq = 1'b1; cyc(); irq = 1'b0;
      repeat (3) cyc();
      if (i == 12) check("wrap_at_15", 32'(b_tick_count), 32'd15);
    end
    check("wrap_to_0", 32'(b_tick_count), 32'd0);
    check("wrap_wide_count", 32'(tick_count), 32'd16);
    check("wrap_tick_pulses", 32'(tick_seen), 32'd16);
    exp_bus(3'd1, 1'b0, 16'h0008);
    stop = 1'b1; cyc(); stop = 1'b0;
    repeat (3) cyc();
    check("wrap_stop_done", 32'(done_seen), 32'd3);

    // Reset asserted during WR_PH abandons the sequence
    exp_bus(3'd2, 1'b0, 16'h0abc); exp_bus(3'd3, 1'b0, 16'h0000);
    period = 32'h0000_0abc; continuous = 1'b1; start = 1'b1;
    cyc(); start = 1'b0;
    cyc();
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("mid_rst_cs", 32'(m_chipselect), 32'd0);
    check("mid_rst_write_n", 32'(m_write_n), 32'd1);
    check("mid_rst_addr", 32'(m_address), 32'd0);
    check("mid_rst_wdata", 32'(m_writedata), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_tick_count", 32'(tick_count), 32'd0);
    check("mid_rst_snapshot", snapshot, 32'd0);
    check("mid_rst_pending", 32'(exp_q.size()), 32'd0);
    cyc();
    reset_n = 1'b1;
    repeat (3) cyc();
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_twin_count", 32'(b_tick_count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/timer_service_master.md
Name: timer_service_master

Overview:
- Avalon-MM initiator that programs and services a 16-bit-data interval-timer slave: 3-bit word address, registered readdata, no waitrequest.
- On command it loads the 32-bit period, starts the timer, acknowledges each timeout interrupt by clearing the status register, and counts serviced ticks.
- Reads a counter snapshot and stops the timer on request.
- Sits between the core's control logic and the timer peripheral, replacing software-driven timer handling.

Parameters:
- TICK_W, 16, width of the serviced-tick counter (wraps modulo 2^TICK_W).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse: program period and start timer (ignored unless IDLE)
- period  in  32  timer period value, sampled at accepted start
- continuous  in  1  1 = periodic, 0 = one-shot; sampled with period
- stop  in  1  one-cycle pulse: stop timer (honoured only in RUN)
- snap_req  in  1  one-cycle pulse: capture and read counter (honoured only in RUN)
- irq  in  1  timer interrupt, level
- m_address  out  3  slave word address
- m_chipselect  out  1  access strobe, exactly one cycle per access
- m_write_n  out  1  0 = write, 1 = read when chipselect high
- m_writedata  out  16  write data
- m_readdata  in  16  slave read data, valid the cycle after the read access
- busy  out  1  high in every state except IDLE
- tick_count  out  TICK_W  serviced interrupts
- tick  out  1  one-cycle pulse per serviced interrupt
- snapshot  out  32  last captured counter value
- snap_valid  out  1  one-cycle pulse when snapshot updates
- done  out  1  one-cycle pulse on return to IDLE

Behaviour:
- Reset values:
  - All outputs 0, except m_write_n=1.
  - State IDLE; internal period/continuous registers 0.
- Bus outputs are registered. Outside the access cycles listed below: m_chipselect=0, m_write_n=1, m_address=0, m_writedata=0.
- Slave register map:
  - 0 status: any write clears the timeout flag.
  - 1 control: bit0 ITO, bit1 CONT, bit2 START, bit3 STOP.
  - 2 period_l, 3 period_h.
  - 4 snap_l: a write captures the counter; read returns bits 15:0.
  - 5 snap_h: read returns bits 31:16.
- FSM, one state per bus cycle:
  - IDLE: on start, latch period/continuous -> WR_PL.
  - WR_PL: write addr 2, data period[15:0] -> WR_PH.
  - WR_PH: write addr 3, data period[31:16] -> WR_CTRL.
  - WR_CTRL: write addr 1, data 0x0007 if continuous else 0x0005 -> RUN.
  - RUN, priority stop > irq > snap_req; if none, stay in RUN:
    - stop -> WR_STOP.
    - irq -> CLR_STAT.
    - snap_req -> SNAP_CAP.
  - CLR_STAT: write addr 0, data 0x0000. tick_count+1 and tick pulse in this cycle -> CLR_WAIT.
  - CLR_WAIT: idle bus cycle, lets the registered slave irq deassert. Continuous -> RUN; one-shot -> IDLE with done.
  - SNAP_CAP: write addr 4, data 0x0000 -> SNAP_RDL.
  - SNAP_RDL: read addr 4 -> SNAP_RDH.
  - SNAP_RDH: read addr 5; capture m_readdata into snapshot[15:0] at end of this cycle -> SNAP_FIN.
  - SNAP_FIN: capture m_readdata into snapshot[31:16]; snap_valid pulse next cycle -> RUN.
  - WR_STOP: write addr 1, data 0x0008 -> IDLE with done.
- Requests outside their honoured states are dropped, not queued. irq is level, so a pending irq is serviced after a snapshot completes.
- start to first RUN cycle: 4 cycles. Snapshot takes 4 bus cycles plus the snap_valid cycle.
- tick_count wraps from all-ones to 0 and is not cleared by start; only reset clears it.
- Reset mid-operation: immediate return to IDLE, bus idle, all counters cleared; a partial programming sequence is abandoned.

Test Plan:
- Start with period=0x0001_0003, continuous=1 -> writes (2,0x0003),(3,0x0001),(1,0x0007) on consecutive cycles; busy=1; then RUN.
- In RUN, raise irq for 2 cycles -> one write (0,0x0000); tick_count 0->1; tick pulses once; FSM back in RUN.
- One-shot start (continuous=0), then irq -> control write 0x0005, status clear, done pulse, busy=0.
- snap_req with slave returning 0x1234 then 0x0001 -> write (4,0), reads 4 then 5; snapshot=0x0001_1234; snap_valid one pulse.
- stop and irq asserted in the same RUN cycle -> write (1,0x0008), no status write, tick_count unchanged, done pulse.
- TICK_W=4: 16 serviced irqs -> tick_count wraps 15->0. Assert reset_n low during WR_PH -> all outputs 0 at once, m_write_n=1, state IDLE.
